branch_pc: RTL
==============

BRANCH_PC -- requirements
Module: branch_pc

Interface
REQ-001 The block SHALL have parameter PC_W, default 10, program counter width in bits.
REQ-002 The block SHALL have parameter LUT_IDX_W, default 4, width of the branch-target table index.
REQ-003 The block SHALL have parameter RESET_PC, default 0, PC value loaded on reset and on start.
REQ-004 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port start  input  1  single-cycle pulse that begins program execution.
REQ-007 Port halt_req  input  1  decoded halt instruction in the current cycle.
REQ-008 Port jump  input  1  decoded unconditional jump.
REQ-009 Port br_neq  input  1  decoded branch-not-equal.
REQ-010 Port br_lt  input  1  decoded branch-less-than.
REQ-011 Port notequal  input  1  ALU not-equal compare flag.
REQ-012 Port lessthan  input  1  ALU signed less-than compare flag.
REQ-013 Port tgt_idx  input  LUT_IDX_W  branch-target table index from the instruction immediate.
REQ-014 Port sc_we  input  1  shift-carry flag write enable.
REQ-015 Port sc_d  input  1  shift-carry value from ALU sc_o.
REQ-016 Port pc  output  PC_W  current instruction address.
REQ-017 Port sc_q  output  1  registered shift-carry, fed back to ALU sc_in.
REQ-018 Port running  output  1  high in state RUN.
REQ-019 Port done  output  1  high in state HALT.

Function
REQ-020 FSM states SHALL be IDLE, RUN and HALT.
REQ-021 In IDLE, start=1 SHALL load pc=RESET_PC and enter RUN the next cycle; all other inputs are ignored.
REQ-022 In RUN, next-PC priority SHALL be halt_req > jump > taken branch > pc+1.
REQ-023 Branch taken SHALL equal (br_neq & notequal) | (br_lt & lessthan); both decodes asserted means either condition takes.
REQ-024 halt_req in RUN SHALL hold pc unchanged and enter HALT the next cycle.
REQ-025 jump or taken branch SHALL load the branch_lut output for tgt_idx with one-cycle latency (pc valid the next cycle).
REQ-026 Sequential increment SHALL wrap from 2^PC_W-1 to 0 with no flag.
REQ-027 start asserted in RUN SHALL be ignored.
REQ-028 In HALT, pc SHALL hold; start=1 SHALL load RESET_PC and enter RUN.
REQ-029 sc_q SHALL load sc_d on sc_we=1 in any state; otherwise hold.
REQ-030 running and done SHALL be registered state decodes, mutually exclusive.

Reset
REQ-031 reset=1 SHALL asynchronously force state IDLE, pc=RESET_PC, sc_q=0, running=0, done=0.
REQ-032 reset mid-branch or mid-halt SHALL abandon the pending update; after release the block waits for start.

Configuration
REQ-033 Macro BRANCH_PC_RELATIVE_EN defined: LUT entries are signed PC_W-bit offsets, and taken target = pc + offset, modulo 2^PC_W.
REQ-034 Macro BRANCH_PC_RELATIVE_EN undefined: LUT entries are absolute target addresses loaded directly into pc.

Structure
REQ-035 Package cpu_pkg SHALL hold PC_W, LUT_IDX_W, RESET_PC defaults and the FSM state enum typedef.
REQ-036 The target table SHALL be a sub-module branch_lut: combinational, 2^LUT_IDX_W entries of PC_W bits, constant contents.

Verification
REQ-037 Reset, then start pulse, run 5 cycles with no control inputs -> pc 0,1,2,3,4,5; running=1.
REQ-038 pc=1023, no control -> next pc=0; state stays RUN.
REQ-039 Absolute mode, LUT[3]=0x040: br_lt=1, lessthan=1, tgt_idx=3 at pc=7 -> pc=0x040 next cycle; with lessthan=0 -> pc=8.
REQ-040 halt_req=1 and jump=1 together at pc=0x010 -> pc stays 0x010, done=1 next cycle; a later start pulse -> pc=0, running=1.
REQ-041 sc_we=1, sc_d=1 -> sc_q=1 next cycle; reset asserted mid-cycle -> sc_q=0, pc=0, and state IDLE immediately, without waiting for a clock.
REQ-042 Relative mode, LUT[2]=-4: jump at pc=2, tgt_idx=2 -> pc=1022.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared defaults and FSM state type for the branch/PC sequencing block.
package cpu_pkg;
    localparam int PC_W_DEF      = 10;
    localparam int LUT_IDX_W_DEF = 4;
    localparam int RESET_PC_DEF  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;
endpackage

// File: rtl/branch_lut.sv
// Constant branch-target table, combinational lookup.
// With BRANCH_PC_RELATIVE_EN entries are signed offsets, otherwise absolute addresses.
module branch_lut #(
    parameter int PC_W      = 10,
    parameter int LUT_IDX_W = 4
) (
    input  logic [LUT_IDX_W-1:0] idx,
    output logic [PC_W-1:0]      target
);
    localparam int ENTRIES = 2 ** LUT_IDX_W;

    logic [PC_W-1:0] entries [ENTRIES];

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
`ifdef BRANCH_PC_RELATIVE_EN
            // Offsets step by 2 starting at -8, so entry 2 is -4.
            localparam int VAL = 2 * gi - 8;
`else
            localparam int VAL = (gi + 1) * 16;
`endif
            assign entries[gi] = PC_W'(VAL);
        end
    endgenerate

    assign target = entries[idx];
endmodule

// File: rtl/branch_pc.sv
// Program counter sequencer: IDLE/RUN/HALT FSM, jump/branch via branch_lut, shift-carry flag.
// Define BRANCH_PC_RELATIVE_EN for pc-relative branch targets; absolute targets otherwise.
module branch_pc
    import cpu_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int LUT_IDX_W = LUT_IDX_W_DEF,
    parameter int RESET_PC  = RESET_PC_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 halt_req,
    input  logic                 jump,
    input  logic                 br_neq,
    input  logic                 br_lt,
    input  logic                 notequal,
    input  logic                 lessthan,
    input  logic [LUT_IDX_W-1:0] tgt_idx,
    input  logic                 sc_we,
    input  logic                 sc_d,
    output logic [PC_W-1:0]      pc,
    output logic                 sc_q,
    output logic                 running,
    output logic                 done
);
    localparam logic [PC_W-1:0] PC_INIT = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] PC_STEP = PC_W'(1);

    state_t          state_reg;
    logic [PC_W-1:0] lut_out;
    logic [PC_W-1:0] jump_target;
    logic            taken;

    branch_lut #(
        .PC_W      (PC_W),
        .LUT_IDX_W (LUT_IDX_W)
    ) u_lut (
        .idx    (tgt_idx),
        .target (lut_out)
    );

    assign taken = (br_neq & notequal) | (br_lt & lessthan);

`ifdef BRANCH_PC_RELATIVE_EN
    assign jump_target = pc + lut_out;
`else
    assign jump_target = lut_out;
`endif

    // running/done are registered alongside the state so they never glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            pc        <= PC_INIT;
            running   <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, HALT: begin
                    if (start) begin
                        state_reg <= RUN;
                        pc        <= PC_INIT;
                        running   <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                RUN: begin
                    if (halt_req) begin
                        state_reg <= HALT;
                        running   <= 1'b0;
                        done      <= 1'b1;
                    end else if (jump || taken) begin
                        pc <= jump_target;
                    end else begin
                        pc <= pc + PC_STEP;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    running   <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sc_q <= 1'b0;
        end else if (sc_we) begin
            sc_q <= sc_d;
        end
    end
endmodule
